// File: rtl/spi_xfer_ctrl.sv
// ============================================================================
// Module      : spi_xfer_ctrl
// Description : SPI master transfer sequencer (CS setup/hold, shift, sample)
//               driven by an external baud rate generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_xfer_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              brg_strobe_i,
    input  logic              brg_rise_i,
    input  logic              brg_fall_i,
    input  logic              miso_i,
    output logic              brg_en_o,
    output logic              brg_sclk_en_o,
    output logic [1:0]        brg_mode_o,
    output logic              mosi_o,
    output logic              cs_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o
);

    localparam int                CNT_W     = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_EDGE = CNT_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               sample_q, sample_d;
    logic [1:0]         mode_q,  mode_d;
    logic [DATA_W-1:0]  rx_q,    rx_d;

    logic               w_cpha;
    logic               w_shift;
    logic               w_sample;

    assign w_cpha = mode_q[0];

    // Both phases shift DATA_W-1 times; the last sample stays in sample_q and
    // is merged on completion, so mosi holds the final bit through CS hold.
    assign w_shift  = w_cpha ? (brg_rise_i && (cnt_q != '0))
                             : (brg_fall_i && (cnt_q != LAST_EDGE));
    assign w_sample = w_cpha ? brg_fall_i : brg_rise_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            sample_q <= 1'b0;
            mode_q   <= 2'b00;
            rx_q     <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            mode_q   <= mode_d;
            rx_q     <= rx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        mode_d   = mode_q;
        rx_d     = rx_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_SETUP;
                    shreg_d  = tx_data_i;
                    mode_d   = mode_i;
                    cnt_d    = '0;
                    sample_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (brg_strobe_i) begin
                    state_d = ST_XFER;
                    cnt_d   = '0;
                end
            end
            ST_XFER: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (w_sample) begin
                        sample_d = miso_i;
                    end
                    if (w_shift) begin
                        shreg_d = {shreg_q[DATA_W-2:0], sample_q};
                    end
                    if (brg_strobe_i) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_EDGE) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (brg_strobe_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!abort_i) begin
                    rx_d = {shreg_q[DATA_W-2:0], sample_q};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign cs_n_o        = (state_q == ST_IDLE);
    assign brg_en_o      = (state_q != ST_IDLE);
    assign brg_sclk_en_o = (state_q == ST_XFER);
    assign brg_mode_o    = mode_q;
    assign mosi_o        = busy_o & shreg_q[DATA_W-1];
    assign done_o        = (state_q == ST_DONE) && !abort_i;
    assign rx_data_o     = rx_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
// ============================================================================
// Module      : tb_spi_xfer_ctrl
// Description : Randomized bench for spi_xfer_ctrl with a transfer-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_xfer_ctrl;

    localparam int W     = 8;
    localparam int NEDGE = 2 * W;
    localparam int SRC_RAND = 0;
    localparam int SRC_LOOP = 1;
    localparam int SRC_ONE  = 2;
    localparam int SRC_PAT  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] tx_data = '0;
    logic         brg_strobe = 1'b0;
    logic         brg_rise = 1'b0;
    logic         brg_fall = 1'b0;
    logic         miso = 1'b0;
    logic         brg_en, brg_sclk_en, mosi, cs_n, busy, done;
    logic [1:0]   brg_mode;
    logic [W-1:0] rx_data;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.DATA_W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .abort_i       (abort),
        .mode_i        (mode),
        .tx_data_i     (tx_data),
        .brg_strobe_i  (brg_strobe),
        .brg_rise_i    (brg_rise),
        .brg_fall_i    (brg_fall),
        .miso_i        (miso),
        .brg_en_o      (brg_en),
        .brg_sclk_en_o (brg_sclk_en),
        .brg_mode_o    (brg_mode),
        .mosi_o        (mosi),
        .cs_n_o        (cs_n),
        .busy_o        (busy),
        .done_o        (done),
        .rx_data_o     (rx_data)
    );

    // Transfer-level model: m_n counts strobes since the start was accepted.
    // 0 = CS setup, 1..NEDGE = clocking, NEDGE+1 = CS hold, NEDGE+2 = done.
    bit           m_active = 1'b0;
    int           m_n = 0;
    int           m_k = 0;
    logic [W-1:0] m_tx = '0;
    logic [W-1:0] m_samp = '0;
    logic [W-1:0] m_rx = '0;
    logic [1:0]   m_mode = 2'b00;

    int           n_vec = 0;
    int           n_err = 0;
    int           done_cnt = 0;
    logic [W-1:0] obs_mosi = '0;
    bit           chk_en = 1'b0;

    int           per = 1;
    int           div = 0;
    bit           lead = 1'b1;
    int           src = SRC_RAND;
    logic [W-1:0] pat = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_n      <= 0;
            m_k      <= 0;
            m_rx     <= '0;
            m_mode   <= 2'b00;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_n      <= 0;
                m_k      <= 0;
                m_tx     <= tx_data;
                m_mode   <= mode;
                m_samp   <= '0;
            end
        end else if (abort) begin
            m_active <= 1'b0;
        end else if (m_n == NEDGE + 2) begin
            m_rx     <= m_samp;
            m_active <= 1'b0;
        end else begin
            if (m_n >= 1 && m_n <= NEDGE && (m_mode[0] ? brg_fall : brg_rise) && m_k < W) begin
                m_samp[W-1-m_k] <= miso;
                m_k             <= m_k + 1;
            end
            if (brg_strobe) m_n <= m_n + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            bit xf;
            xf = m_active && m_n >= 1 && m_n <= NEDGE;
            chk("busy",     32'(busy),        32'(m_active));
            chk("cs_n",     32'(cs_n),        32'(!m_active));
            chk("brg_en",   32'(brg_en),      32'(m_active));
            chk("sclk_en",  32'(brg_sclk_en), 32'(xf));
            chk("done",     32'(done),        32'(m_active && m_n == NEDGE + 2 && !abort));
            chk("brg_mode", 32'(brg_mode),    32'(m_mode));
            chk("rx_data",  32'(rx_data),     32'(m_rx));
            if (!m_active) begin
                chk("mosi_idle", 32'(mosi), 32'd0);
            end else if (xf && (m_mode[0] ? brg_fall : brg_rise) && m_k < W) begin
                chk("mosi_bit", 32'(mosi), 32'(m_tx[W-1-m_k]));
                obs_mosi = {obs_mosi[W-2:0], mosi};
            end
            if (done) done_cnt++;
        end
    end

    // Apply one cycle of inputs at the current falling edge, then wait a cycle.
    task automatic step(input bit st, input bit ab, input bit rs);
        start = st;
        abort = ab;
        rst   = rs;
        brg_strobe = 1'b0;
        brg_rise   = 1'b0;
        brg_fall   = 1'b0;
        if (!brg_sclk_en) lead = 1'b1;
        if (!brg_en) begin
            div = 0;
        end else if (div >= per - 1) begin
            div = 0;
            brg_strobe = 1'b1;
            if (brg_sclk_en) begin
                brg_rise = lead;
                brg_fall = !lead;
                lead = !lead;
            end
        end else begin
            div++;
        end
        case (src)
            SRC_LOOP: miso = mosi;
            SRC_ONE:  miso = 1'b1;
            SRC_PAT:  miso = (m_k < W) ? pat[W-1-m_k] : 1'b0;
            default:  miso = 1'($urandom);
        endcase
        if (busy) begin
            tx_data = W'($urandom);
            mode    = 2'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    // Runs one transfer from the current falling edge until the model is idle.
    task automatic run(input logic [W-1:0] tx, input logic [1:0] md, input int s,
                       input logic [W-1:0] p, input int ab_at, input int rs_at,
                       input bit rst_hold, output int ndone);
        bit ab_used = 1'b0, rs_used = 1'b0, rst_used = 1'b0;
        int cyc = 0;
        int base = done_cnt;
        src = s;
        pat = p;
        per = $urandom_range(1, 3);
        tx_data = tx;
        mode = md;
        step(1'b1, 1'b0, 1'b0);
        while (m_active && cyc < 500) begin
            bit a = 1'b0, r = 1'b0, q = 1'b0;
            if (ab_at > 0 && !ab_used && m_n == ab_at + 1) begin a = 1'b1; ab_used = 1'b1; end
            if (rs_at > 0 && !rs_used && m_n == rs_at + 1) begin r = 1'b1; rs_used = 1'b1; end
            if (rst_hold && !rst_used && m_n == NEDGE + 1) begin q = 1'b1; rst_used = 1'b1; end
            step(r, a, q);
            cyc++;
        end
        if (cyc >= 500) begin
            n_err++;
            $display("FAIL timeout: transfer did not finish within 500 cycles");
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        brg_strobe = 1'b0; brg_rise = 1'b0; brg_fall = 1'b0;
        #2;
        ndone = done_cnt - base;
    endtask

    initial begin
        int nd;
        int nd2;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        #2;
        chk("rst_rx",   32'(rx_data), 32'h0);
        chk("rst_cs_n", 32'(cs_n),    32'h1);
        chk("rst_mosi", 32'(mosi),    32'h0);
        chk("rst_busy", 32'(busy),    32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        run(8'hA5, 2'd0, SRC_LOOP, '0, 0, 0, 1'b0, nd);
        chk("m0_rx",   32'(rx_data),  32'hA5);
        chk("m0_mosi", 32'(obs_mosi), 32'hA5);
        chk("m0_done", 32'(nd),       32'd1);
        idle(2);

        run(8'h3C, 2'd3, SRC_ONE, '0, 0, 0, 1'b0, nd);
        chk("m3_rx",   32'(rx_data),  32'hFF);
        chk("m3_mosi", 32'(obs_mosi), 32'h3C);
        chk("m3_mode", 32'(brg_mode), 32'h3);
        idle(1);

        run(W'($urandom), 2'd1, SRC_PAT, 8'h96, 0, 0, 1'b0, nd);
        chk("m1_rx",   32'(rx_data), 32'h96);
        chk("m1_done", 32'(nd),      32'd1);
        idle(2);

        run(W'($urandom), 2'd0, SRC_RAND, '0, 9, 0, 1'b0, nd);
        chk("abort_done", 32'(nd),      32'd0);
        chk("abort_rx",   32'(rx_data), 32'h96);
        chk("abort_cs_n", 32'(cs_n),    32'h1);
        idle(1);
        run(8'h5A, 2'd2, SRC_LOOP, '0, 0, 0, 1'b0, nd);
        chk("post_abort_rx", 32'(rx_data), 32'h5A);
        idle(2);

        run(8'hC3, 2'd0, SRC_LOOP, '0, 0, 5, 1'b0, nd);
        chk("restart_done", 32'(nd),      32'd1);
        chk("restart_rx",   32'(rx_data), 32'hC3);
        idle(2);

        run(8'hFF, 2'd1, SRC_LOOP, '0, 0, 0, 1'b1, nd);
        chk("hold_rst_rx",   32'(rx_data),  32'h0);
        chk("hold_rst_mode", 32'(brg_mode), 32'h0);
        chk("hold_rst_done", 32'(nd),       32'd0);
        idle(2);

        run(8'h11, 2'd0, SRC_LOOP, '0, 0, 0, 1'b0, nd);
        chk("b2b_cs_gap", 32'(cs_n), 32'h1);
        run(8'h22, 2'd1, SRC_LOOP, '0, 0, 0, 1'b0, nd2);
        chk("b2b_rx",   32'(rx_data),  32'h22);
        chk("b2b_done", 32'(nd + nd2), 32'd2);
        idle(2);

        for (int i = 0; i < 24; i++) begin
            int ab;
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, NEDGE) : 0;
            run(W'($urandom), 2'($urandom), SRC_RAND, '0, ab, 0, 1'b0, nd);
            chk("rand_done", 32'(nd), 32'(ab == 0));
            idle($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, gives the transfer word width in bits (legal 4..32).
REQ-002 clk  input  1  global clock; all logic is on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle transfer request; accepted only in IDLE.
REQ-005 abort  input  1  terminates any transfer in progress.
REQ-006 mode  input  2  SPI mode {cpol,cpha}; sampled at start accept.
REQ-007 tx_data  input  DATA_W  word to send, MSB first; sampled at start accept.
REQ-008 brg_strobe / brg_rise / brg_fall  input  1 each  strobe, leading-edge and trailing-edge pulses from the baud rate generator.
REQ-009 brg_en / brg_sclk_en  output  1 each  baud generator strobe enable and SCLK toggle enable.
REQ-010 brg_mode  output  2  latched mode, forwarded to the baud generator.
REQ-011 miso  input  1  serial data in; mosi  output  1  serial data out.
REQ-012 cs_n  output  1  chip select, active-low.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse at normal completion.
REQ-015 rx_data  output  DATA_W  last fully received word.

Function
REQ-016 The FSM states SHALL be IDLE, SETUP, XFER, HOLD and DONE.
REQ-017 IDLE -> SETUP on start: latch tx_data into the shift register and mode into brg_mode; cs_n=0 and brg_en=1 from the next cycle.
REQ-018 start SHALL be ignored when busy=1, with no latching and no state change.
REQ-019 SETUP (CS setup time): on the first brg_strobe the FSM SHALL go to XFER; brg_sclk_en=0 throughout SETUP.
REQ-020 XFER: brg_sclk_en=1; a log2(2*DATA_W+1)-bit edge counter SHALL count brg_strobe pulses from 0.
REQ-021 When cpha=0, mosi SHALL present the MSB from SETUP entry, miso SHALL be sampled into the LSB on brg_rise, and the register SHALL shift on brg_fall except on the final edge.
REQ-022 When cpha=1, the register SHALL shift out on brg_rise (the first brg_rise presents the MSB) and miso SHALL be sampled on brg_fall.
REQ-023 On the strobe that brings the counter to 2*DATA_W, the FSM SHALL move to HOLD (registered), so brg_sclk_en=0 before the next strobe and SCLK rests at idle polarity.
REQ-024 HOLD (CS hold time): on the first brg_strobe the FSM SHALL go to DONE.
REQ-025 DONE lasts exactly one cycle: done=1, rx_data<=shift register, cs_n<=1, brg_en<=0, then IDLE.
REQ-026 The minimum time from done to the next accepted start SHALL be 1 cycle (back-to-back start accepted in the cycle after DONE).
REQ-027 abort in any non-IDLE state SHALL within 1 cycle force IDLE, cs_n=1, brg_en=0, brg_sclk_en=0, with no done pulse and rx_data unchanged.
REQ-028 abort SHALL take priority over a same-cycle strobe or over the completion transition.
REQ-029 abort and start together in IDLE: start SHALL win.
REQ-030 mosi SHALL be held at the shift register MSB and SHALL be 0 in IDLE.
REQ-031 Changes to mode or tx_data while busy SHALL have no effect.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL enter IDLE with cs_n=1, busy=0, done=0, brg_en=0, brg_sclk_en=0, brg_mode=0, mosi=0, rx_data=0, shift register=0 and edge counter=0.
REQ-033 Reset mid-transfer SHALL behave as REQ-032 with no done pulse.

Verification
REQ-034 Mode 0, DATA_W=8, tx_data=0xA5, miso loopback from mosi -> 16 SCLK edges, mosi bits 1,0,1,0,0,1,0,1; done once; rx_data=0xA5; cs_n low from SETUP through DONE.
REQ-035 Mode 3, tx_data=0x3C, miso held 1 -> rx_data=0xFF; MSB appears on the first brg_rise; brg_sclk_en drops after the 16th strobe.
REQ-036 Mode 1, miso driven with 0x96 on trailing edges -> rx_data=0x96; 8 samples, all on brg_fall.
REQ-037 start pulsed again at XFER edge 5 -> ignored; exactly one done; rx_data matches the first word only.
REQ-038 abort at edge 9 -> next cycle IDLE, cs_n=1, brg_en=0, no done, rx_data keeps its previous value; a following start completes normally.
REQ-039 rst=1 asserted in HOLD -> all outputs at REQ-032 values on the next edge; back-to-back starts after DONE yield two transfers separated by 1 idle cycle with cs_n high.
